audio_frame_feeder: RTL and testbench

Upstream sample-delivery stage for the audio DAC serializer. It buffers stereo frames (left/right 16-bit samples) from a producer through a valid/ready FIFO. It presents one frame on stable parallel outputs per LRCK period and advances on each LRCK falling edge, which is the DAC's frame boundary. It replaces the fixed sine ROM as the DAC's data source and reports underruns.

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_sync_fifo.sv | 65 ++++++
 rtl/audio_frame_feeder.sv | 118 +++++++++++
 tb/tb_audio_frame_feeder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, clocking constants and the stereo frame type.
// No logic; widths and rates used by the DAC data path and its benches.
// LRCK_DIV is the number of iCLK cycles per LRCK period.
package audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 16;
  localparam int REF_CLK          = 18432000;
  localparam int SAMPLE_RATE      = 48000;
  localparam int LRCK_DIV         = REF_CLK / SAMPLE_RATE;

  typedef struct packed {
    logic [AUDIO_DATA_WIDTH-1:0] left;
    logic [AUDIO_DATA_WIDTH-1:0] right;
  } frame_t;

endpackage

// File: rtl/audio_sync_fifo.sv
// Generic single-clock FIFO built from a register array, with a separate level counter.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push_rdy drops when full; pops on an empty FIFO are ignored.
module audio_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic [AW:0]      level,
  output logic             empty
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             push_fire;
  logic             pop_fire;

  assign full      = (count == DEPTH_L);
  assign empty     = (count == '0);
  assign push_rdy  = ~full;
  assign push_fire = push_vld & ~full;
  assign pop_fire  = pop_vld & ~empty;
  assign pop_dat   = mem[rd_ptr];
  assign level     = count;

  // Storage needs no reset: the level counter guards every read.
  always_ff @(posedge iCLK) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_frame_feeder.sv
// Buffers producer stereo frames and hands one to the DAC per LRCK falling edge; counts underruns.
// Latency: outputs update at the edge closing the tick cycle, strobe high the following cycle.
// Backpressure: oIn_Ready low while the FIFO holds FIFO_DEPTH frames.
module audio_frame_feeder
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [DATA_WIDTH-1:0] iIn_L,
  input  logic [DATA_WIDTH-1:0] iIn_R,
  input  logic                  iIn_Valid,
  output logic                  oIn_Ready,
  input  logic                  iAUD_LRCK,
  input  logic                  iMute,
  input  logic                  iClr_Underrun,
  output logic [DATA_WIDTH-1:0] oOut_L,
  output logic [DATA_WIDTH-1:0] oOut_R,
  output logic                  oFrame_Strobe,
  output logic [ADDR_WIDTH:0]   oLevel,
  output logic                  oUnderrun,
  output logic [15:0]           oUnderrun_Cnt
);

  logic                    lrck_q;
  logic                    tick;
  logic                    fifo_empty;
  logic                    underrun_evt;
  logic [2*DATA_WIDTH-1:0] head_dat;

  logic [DATA_WIDTH-1:0]   out_l;
  logic [DATA_WIDTH-1:0]   out_r;
  logic [DATA_WIDTH-1:0]   out_l_nxt;
  logic [DATA_WIDTH-1:0]   out_r_nxt;
  logic                    strobe;
  logic                    underrun;
  logic                    underrun_nxt;
  logic [15:0]             underrun_cnt;
  logic [15:0]             underrun_cnt_nxt;

  audio_sync_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_fifo (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .push_vld (iIn_Valid),
    .push_dat ({iIn_L, iIn_R}),
    .push_rdy (oIn_Ready),
    .pop_vld  (tick),
    .pop_dat  (head_dat),
    .level    (oLevel),
    .empty    (fifo_empty)
  );

  // lrck_q resets low so a high LRCK at reset release cannot fake a falling edge.
  assign tick         = lrck_q & ~iAUD_LRCK;
  assign underrun_evt = tick & fifo_empty;

  always_comb begin
    out_l_nxt        = out_l;
    out_r_nxt        = out_r;
    underrun_nxt     = underrun;
    underrun_cnt_nxt = underrun_cnt;

    if (tick) begin
      if (fifo_empty || iMute) begin
        out_l_nxt = '0;
        out_r_nxt = '0;
      end else begin
        out_l_nxt = head_dat[2*DATA_WIDTH-1:DATA_WIDTH];
        out_r_nxt = head_dat[DATA_WIDTH-1:0];
      end
    end

    // An underrun in the clear cycle is still recorded, counted from a cleared counter.
    if (underrun_evt) begin
      underrun_nxt = 1'b1;
      if (iClr_Underrun) begin
        underrun_cnt_nxt = 16'd1;
      end else if (underrun_cnt != 16'hFFFF) begin
        underrun_cnt_nxt = underrun_cnt + 16'd1;
      end
    end else if (iClr_Underrun) begin
      underrun_nxt     = 1'b0;
      underrun_cnt_nxt = '0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lrck_q       <= 1'b0;
      out_l        <= '0;
      out_r        <= '0;
      strobe       <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      lrck_q       <= iAUD_LRCK;
      out_l        <= out_l_nxt;
      out_r        <= out_r_nxt;
      strobe       <= tick;
      underrun     <= underrun_nxt;
      underrun_cnt <= underrun_cnt_nxt;
    end
  end

  assign oOut_L        = out_l;
  assign oOut_R        = out_r;
  assign oFrame_Strobe = strobe;
  assign oUnderrun     = underrun;
  assign oUnderrun_Cnt = underrun_cnt;

endmodule

// File: tb/tb_audio_frame_feeder.sv
// Directed bench for audio_frame_feeder: a table of push/tick operations with hand-computed
// results, plus hand-written sequences for reset, clear-vs-underrun, saturation and full+tick.
module tb_audio_frame_feeder;
  import audio_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [15:0] iIn_L;
  logic [15:0] iIn_R;
  logic        iIn_Valid;
  logic        oIn_Ready;
  logic        iAUD_LRCK;
  logic        iMute;
  logic        iClr_Underrun;
  logic [15:0] oOut_L;
  logic [15:0] oOut_R;
  logic        oFrame_Strobe;
  logic [3:0]  oLevel;
  logic        oUnderrun;
  logic [15:0] oUnderrun_Cnt;

  int checks = 0;
  int errors = 0;

  audio_frame_feeder #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (8),
    .ADDR_WIDTH (3)
  ) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iIn_L         (iIn_L),
    .iIn_R         (iIn_R),
    .iIn_Valid     (iIn_Valid),
    .oIn_Ready     (oIn_Ready),
    .iAUD_LRCK     (iAUD_LRCK),
    .iMute         (iMute),
    .iClr_Underrun (iClr_Underrun),
    .oOut_L        (oOut_L),
    .oOut_R        (oOut_R),
    .oFrame_Strobe (oFrame_Strobe),
    .oLevel        (oLevel),
    .oUnderrun     (oUnderrun),
    .oUnderrun_Cnt (oUnderrun_Cnt)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        is_tick;
    logic        push;
    logic        mute;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic [3:0]  exp_lvl;
    logic        exp_rdy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic void addv(input logic is_tick, input logic push, input logic mute,
                               input logic [15:0] l, input logic [15:0] r,
                               input logic [15:0] exp_l, input logic [15:0] exp_r,
                               input logic [3:0] exp_lvl, input logic exp_rdy,
                               input logic [15:0] exp_cnt);
    vec_t v;
    v.is_tick = is_tick; v.push = push; v.mute = mute; v.l = l; v.r = r;
    v.exp_l = exp_l; v.exp_r = exp_r; v.exp_lvl = exp_lvl; v.exp_rdy = exp_rdy;
    v.exp_cnt = exp_cnt;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // One LRCK period compressed to two cycles; push/mute/clear are applied in the tick cycle.
  task automatic do_tick(input logic push, input logic [15:0] l, input logic [15:0] r,
                         input logic mute, input logic clr);
    iAUD_LRCK = 1'b1;
    step();
    iAUD_LRCK = 1'b0;
    iIn_Valid = push; iIn_L = l; iIn_R = r; iMute = mute; iClr_Underrun = clr;
    step();
    iIn_Valid = 1'b0; iMute = 1'b0; iClr_Underrun = 1'b0;
  endtask

  task automatic do_push(input logic [15:0] l, input logic [15:0] r);
    iIn_Valid = 1'b1; iIn_L = l; iIn_R = r;
    step();
    iIn_Valid = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [15:0] el, input logic [15:0] er,
                             input logic [3:0] lvl, input logic rdy, input logic [15:0] cnt,
                             input logic flag);
    chk({tag, " out_l"}, 32'(oOut_L), 32'(el));
    chk({tag, " out_r"}, 32'(oOut_R), 32'(er));
    chk({tag, " level"}, 32'(oLevel), 32'(lvl));
    chk({tag, " ready"}, 32'(oIn_Ready), 32'(rdy));
    chk({tag, " ucnt"}, 32'(oUnderrun_Cnt), 32'(cnt));
    chk({tag, " uflag"}, 32'(oUnderrun), 32'(flag));
  endtask

  initial begin
    frame_t f;
    int strobes;

    iRST = 1'b1; iIn_L = '0; iIn_R = '0; iIn_Valid = 1'b0; iAUD_LRCK = 1'b1;
    iMute = 1'b0; iClr_Underrun = 1'b0;

    // Reset state, with LRCK high so a bad lrck_q reset value would fake a tick on release.
    step(); step();
    check_state("reset", 16'h0, 16'h0, 4'd0, 1'b1, 16'h0, 1'b0);
    chk("reset strobe", 32'(oFrame_Strobe), 32'(0));
    iRST = 1'b0; iAUD_LRCK = 1'b0;
    step();
    chk("post-reset strobe", 32'(oFrame_Strobe), 32'(0));
    step();
    chk("post-reset strobe2", 32'(oFrame_Strobe), 32'(0));
    chk("post-reset uflag", 32'(oUnderrun), 32'(0));

    // Real-rate LRCK with nothing queued: one strobe per period, counter 1,2,3.
    for (int p = 0; p < 3; p++) begin
      strobes = 0;
      iAUD_LRCK = 1'b1;
      repeat (LRCK_DIV/2) begin step(); strobes += int'(oFrame_Strobe); end
      iAUD_LRCK = 1'b0;
      step();
      strobes += int'(oFrame_Strobe);
      chk($sformatf("idle p%0d strobe", p), 32'(oFrame_Strobe), 32'(1));
      check_state($sformatf("idle p%0d", p), 16'h0, 16'h0, 4'd0, 1'b1, 16'(p+1), 1'b1);
      repeat (LRCK_DIV/2 - 1) begin step(); strobes += int'(oFrame_Strobe); end
      chk($sformatf("idle p%0d strobes", p), 32'(strobes), 32'(1));
    end
    iClr_Underrun = 1'b1; step(); iClr_Underrun = 1'b0;
    check_state("clear", 16'h0, 16'h0, 4'd0, 1'b1, 16'h0, 1'b0);

    // Fill to full, one ignored push, then drain in order.
    for (int i = 0; i < 8; i++)
      addv(1'b0, 1'b1, 1'b0, 16'(16'h1000+i), 16'(16'h2000+i), 16'h0, 16'h0,
           4'(i+1), (i < 7), 16'h0);
    addv(1'b0, 1'b1, 1'b0, 16'h1008, 16'h2008, 16'h0, 16'h0, 4'd8, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++)
      addv(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'(16'h1000+i), 16'(16'h2000+i),
           4'(7-i), 1'b1, 16'h0);
    // Push and tick together at level 3.
    for (int k = 0; k < 3; k++)
      addv(1'b0, 1'b1, 1'b0, 16'(16'h3000+k), 16'(16'h4000+k), 16'h1007, 16'h2007,
           4'(k+1), 1'b1, 16'h0);
    addv(1'b1, 1'b1, 1'b0, 16'h3003, 16'h4003, 16'h3000, 16'h4000, 4'd3, 1'b1, 16'h0);
    addv(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h3001, 16'h4001, 4'd2, 1'b1, 16'h0);
    addv(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h3002, 16'h4002, 4'd1, 1'b1, 16'h0);
    addv(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h3003, 16'h4003, 4'd0, 1'b1, 16'h0);
    // Push and tick together while empty: underrun, frame stored, out next tick.
    addv(1'b1, 1'b1, 1'b0, 16'h5555, 16'h6666, 16'h0, 16'h0, 4'd1, 1'b1, 16'h1);
    addv(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5555, 16'h6666, 4'd0, 1'b1, 16'h1);
    // Mute drains frames without underrun; the next empty tick does underrun.
    for (int k = 0; k < 4; k++)
      addv(1'b0, 1'b1, 1'b0, 16'(16'h7000+k), 16'(16'h8000+k), 16'h5555, 16'h6666,
           4'(k+1), 1'b1, 16'h1);
    for (int k = 0; k < 4; k++)
      addv(1'b1, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 4'(3-k), 1'b1, 16'h1);
    addv(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b1, 16'h2);

    for (int k = 0; k < vq.size(); k++) begin
      if (vq[k].is_tick) do_tick(vq[k].push, vq[k].l, vq[k].r, vq[k].mute, 1'b0);
      else               do_push(vq[k].l, vq[k].r);
      chk($sformatf("v%0d strobe", k), 32'(oFrame_Strobe), 32'(vq[k].is_tick));
      check_state($sformatf("v%0d", k), vq[k].exp_l, vq[k].exp_r, vq[k].exp_lvl,
                  vq[k].exp_rdy, vq[k].exp_cnt, (vq[k].exp_cnt != 16'h0));
    end

    // Clear coinciding with an underrun at count 5.
    for (int k = 0; k < 3; k++) do_tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("cnt5", 32'(oUnderrun_Cnt), 32'(5));
    do_tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("clr+underrun cnt", 32'(oUnderrun_Cnt), 32'(1));
    chk("clr+underrun flag", 32'(oUnderrun), 32'(1));
    iClr_Underrun = 1'b1; step(); iClr_Underrun = 1'b0;
    chk("clr cnt", 32'(oUnderrun_Cnt), 32'(0));
    chk("clr flag", 32'(oUnderrun), 32'(0));

    // Saturation: preload the counter just below the top.
    force dut.underrun_cnt = 16'hFFFE;
    #1;
    release dut.underrun_cnt;
    do_tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("sat to ffff", 32'(oUnderrun_Cnt), 32'(16'hFFFF));
    do_tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("sat hold", 32'(oUnderrun_Cnt), 32'(16'hFFFF));
    chk("sat level", 32'(oLevel), 32'(0));

    // Full plus tick with the producer holding a frame: pop only, push lands next cycle.
    for (int k = 0; k < 8; k++) do_push(16'(16'h9000+k), 16'(16'hA000+k));
    chk("full ready", 32'(oIn_Ready), 32'(0));
    f.left = 16'h9008; f.right = 16'hA008;
    iIn_Valid = 1'b1; iIn_L = f.left; iIn_R = f.right;
    iAUD_LRCK = 1'b1; step();
    chk("full hold level", 32'(oLevel), 32'(8));
    iAUD_LRCK = 1'b0; step();
    chk("full tick level", 32'(oLevel), 32'(7));
    chk("full tick ready", 32'(oIn_Ready), 32'(1));
    chk("full tick out_l", 32'(oOut_L), 32'(16'h9000));
    chk("full tick out_r", 32'(oOut_R), 32'(16'hA000));
    step();
    iIn_Valid = 1'b0;
    chk("refill level", 32'(oLevel), 32'(8));
    chk("refill ready", 32'(oIn_Ready), 32'(0));

    // Reset mid-operation discards the buffered frames.
    iRST = 1'b1; step(); iRST = 1'b0;
    check_state("mid reset", 16'h0, 16'h0, 4'd0, 1'b1, 16'h0, 1'b0);
    do_tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check_state("after reset tick", 16'h0, 16'h0, 4'd0, 1'b1, 16'h1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
